hc_sr04_sensor_emu: RTL and testbench
=====================================

// Module: hc_sr04_sensor_emu
// PURPOSE
// - Synthesizable HC-SR04 sensor emulator: the responder end of the trigger/echo interface driven by hc_sr04.
// - Qualifies the trigger pulse, waits the ultrasonic burst time, then drives echo high for a width set by a distance input.
// - Used as a closed-loop stand-in for the real sensor in benches and on board.
// PARAMETERS
// - TRIG_MIN_CYCLES  500        min trigger high width to accept (10 us at 50 MHz)
// - BURST_CYCLES     10000      delay from accepted trigger to echo rise (8 x 40 kHz = 200 us)
// - CYCLES_PER_CM    2941       echo cycles per cm (58.82 us/cm at 50 MHz)
// - MIN_CM           2          smallest in-range distance
// - MAX_CM           400        largest in-range distance
// - TIMEOUT_CYCLES   1900000    echo width when out of range (38 ms)
// - HOLDOFF_CYCLES   500000     dead time after echo fall before re-arming (10 ms)
// PORTS
// - clock        in   1   system clock, 50 MHz, all logic on rising edge
// - reset        in   1   synchronous, active-high
// - trigger      in   1   trigger from controller; asynchronous, 2-FF synchronized internally
// - distance_cm  in   9   emulated target distance in cm; sampled when trigger is accepted
// - echo         out  1   echo pulse to controller, registered
// - busy         out  1   high from trigger acceptance until end of HOLDOFF
// - timeout      out  1   one-cycle pulse at echo fall of an out-of-range measurement
// - runt         out  1   one-cycle pulse when a trigger shorter than TRIG_MIN_CYCLES is rejected
// BEHAVIOUR
// - Reset: one clock, one synchronous active-high reset.
//   - On the first rising clock edge with reset high: state=IDLE, all counters=0, sync FFs=0.
//   - All four outputs are 0.
//   - A reset mid-echo drops echo on that same edge.
// - trig_s: trigger after the 2-FF synchronizer.
// - trig_rise: trig_s=1 and the previous trig_s=0.
// - States:
//   - IDLE: on trig_rise go to TRIG_HI with tcnt=1. A trigger already high on entry is ignored until it falls and rises again.
//   - TRIG_HI: while trig_s=1, tcnt increments and saturates at TRIG_MIN_CYCLES. When trig_s=0:
//     - If tcnt >= TRIG_MIN_CYCLES: go to BURST, latch distance_cm, busy=1.
//     - Else: pulse runt, go to IDLE.
//   - BURST: count BURST_CYCLES clocks. On the last one go to ECHO, set echo=1 and load wcnt.
//     - wcnt = distance_cm*CYCLES_PER_CM when MIN_CM <= distance <= MAX_CM.
//     - wcnt = TIMEOUT_CYCLES otherwise, and the oor flag is set.
//   - ECHO: echo stays high exactly wcnt clocks. Then echo=0, timeout pulses if oor, go to HOLDOFF.
//   - HOLDOFF: count HOLDOFF_CYCLES. trigger is ignored. At the end busy=0 and go to IDLE.
// - Latency: echo rises exactly BURST_CYCLES+3 clocks after the first edge that samples the trigger pin low.
// - Arithmetic: wcnt is 32-bit unsigned. The product is 9 x 12 bits, so it cannot overflow.
// - Triggers arriving in BURST, ECHO or HOLDOFF: no effect, no runt, no restart.
// - distance_cm changes after acceptance: no effect until the next measurement.
// STRUCTURE
// - hc_sr04_pkg:
//   - state encoding localparams: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF
//   - clock-rate constants: CLK_HZ=50_000_000, US_PER_CM_X100=5882
//   - default CYCLES_PER_CM, shared with hc_sr04 range scaling
// - Sub-module sync_2ff: generic 2-flop synchronizer with reset; instantiated for trigger.
// - Top level holds one FSM, one shared down-counter for BURST, ECHO and HOLDOFF, and tcnt.
// TESTING (50 MHz clock, default params unless noted; loop the emulator into hc_sr04 where range is checked)
// - Accept: trigger high 500 clk, distance_cm=2.
//   - echo rises BURST_CYCLES+3 clk after trigger falls and is high 5882 clk.
//   - hc_sr04 range=5882. busy=1 through holdoff.
// - Distance 10 cm: echo high 29410 clk, range=29410. Distance 400 cm: echo high 1176400 clk, timeout=0.
// - Runt: trigger high 499 clk.
//   - runt pulses once, echo stays 0, busy stays 0.
//   - A following 500-clk trigger is accepted normally.
// - Out of range: distance_cm=401, then distance_cm=0.
//   - echo high exactly 1900000 clk each time.
//   - timeout pulses once at each echo fall.
// - Ignore and reset:
//   - A 500-clk trigger during ECHO and again in HOLDOFF: echo width unchanged, no new echo.
//   - reset asserted mid-ECHO: echo=0 and busy=0 on that edge, FSM in IDLE.
// - Back-to-back (BURST_CYCLES=100, HOLDOFF_CYCLES=200):
//   - Three measurements at 2, 10, 3 cm give widths 5882, 29410, 8823.
//   - Each new trigger is issued immediately after busy falls.

Source files
------------

// File: rtl/hc_sr04_pkg.sv
// Shared constants for the HC-SR04 controller and its sensor emulator.
// States: IDLE wait | TRIG_HI qualify trigger | BURST delay | ECHO pulse | HOLDOFF dead time.
package hc_sr04_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t TRIG_HI = 3'd1;
  localparam state_t BURST   = 3'd2;
  localparam state_t ECHO    = 3'd3;
  localparam state_t HOLDOFF = 3'd4;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned US_PER_CM_X100 = 5882;

  // 50 cycles/us * 58.82 us/cm = 2941 cycles/cm
  localparam int unsigned DEFAULT_CYCLES_PER_CM = (CLK_HZ / 1_000_000) * US_PER_CM_X100 / 100;

  function automatic logic dist_in_range(input logic [8:0] d,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (32'(d) >= lo) && (32'(d) <= hi);
  endfunction

  function automatic logic [31:0] echo_cycles(input logic [8:0] d,
                                              input int unsigned cpc,
                                              input int unsigned lo,
                                              input int unsigned hi,
                                              input int unsigned tmo);
    if (dist_in_range(d, lo, hi))
      return 32'(d) * cpc;
    else
      return tmo;
  endfunction

endpackage

// File: rtl/hc_sr04_sensor_emu_sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc_sr04_sensor_emu.sv
// HC-SR04 responder: qualifies the trigger, waits the burst time, then drives an
// echo pulse whose width encodes distance_cm (or a timeout width when out of range).
module hc_sr04_sensor_emu
  import hc_sr04_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYCLES = 500,
  parameter int unsigned BURST_CYCLES    = 10000,
  parameter int unsigned CYCLES_PER_CM   = DEFAULT_CYCLES_PER_CM,
  parameter int unsigned MIN_CM          = 2,
  parameter int unsigned MAX_CM          = 400,
  parameter int unsigned TIMEOUT_CYCLES  = 1900000,
  parameter int unsigned HOLDOFF_CYCLES  = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       timeout,
  output logic       runt
);

  localparam int TW = $clog2(TRIG_MIN_CYCLES + 1);
  localparam logic [TW-1:0] TMIN = TW'(TRIG_MIN_CYCLES);

  state_t        state;
  logic [31:0]   cnt;
  logic [TW-1:0] tcnt;
  logic [8:0]    dist_lat;
  logic          oor;
  logic          trig_s;
  logic          trig_prev;
  logic          trig_rise;
  logic [31:0]   echo_width;
  logic          in_range;

  sync_2ff #(.WIDTH(1)) u_trig_sync (
    .clock (clock),
    .reset (reset),
    .d     (trigger),
    .q     (trig_s)
  );

  assign trig_rise  = trig_s & ~trig_prev;
  assign in_range   = dist_in_range(dist_lat, MIN_CM, MAX_CM);
  assign echo_width = echo_cycles(dist_lat, CYCLES_PER_CM, MIN_CM, MAX_CM, TIMEOUT_CYCLES);

  // One down-counter serves BURST, ECHO and HOLDOFF; each phase ends when it reads zero.
  // BURST is loaded with the full count so echo rises BURST_CYCLES+3 edges after the pin falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      dist_lat  <= '0;
      oor       <= 1'b0;
      trig_prev <= 1'b0;
      echo      <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      runt      <= 1'b0;
    end else begin
      trig_prev <= trig_s;
      timeout   <= 1'b0;
      runt      <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_rise) begin
            state <= TRIG_HI;
            tcnt  <= TW'(1);
          end
        end
        TRIG_HI: begin
          if (trig_s) begin
            if (tcnt < TMIN) tcnt <= tcnt + TW'(1);
          end else if (tcnt >= TMIN) begin
            state    <= BURST;
            dist_lat <= distance_cm;
            busy     <= 1'b1;
            cnt      <= BURST_CYCLES;
          end else begin
            runt  <= 1'b1;
            state <= IDLE;
          end
        end
        BURST: begin
          if (cnt == 32'd0) begin
            state <= ECHO;
            echo  <= 1'b1;
            oor   <= ~in_range;
            cnt   <= echo_width - 32'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ECHO: begin
          if (cnt == 32'd0) begin
            state   <= HOLDOFF;
            echo    <= 1'b0;
            timeout <= oor;
            cnt     <= HOLDOFF_CYCLES - 32'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        HOLDOFF: begin
          if (cnt == 32'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_sr04_sensor_emu.sv
// Self-checking bench for hc_sr04_sensor_emu with scaled-down timing parameters.
module tb_hc_sr04_sensor_emu;

  localparam int TMIN  = 20;
  localparam int BST   = 50;
  localparam int CPC   = 7;
  localparam int MINC  = 2;
  localparam int MAXC  = 40;
  localparam int TMO   = 500;
  localparam int HOLD  = 100;
  localparam int LIMIT = BST + TMO + HOLD + 60;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distance_cm = '0;
  logic       echo, busy, timeout, runt;

  int n_tests = 0;
  int n_fail  = 0;
  int runt_cnt = 0;
  int to_cnt   = 0;

  hc_sr04_sensor_emu #(
    .TRIG_MIN_CYCLES (TMIN),
    .BURST_CYCLES    (BST),
    .CYCLES_PER_CM   (CPC),
    .MIN_CM          (MINC),
    .MAX_CM          (MAXC),
    .TIMEOUT_CYCLES  (TMO),
    .HOLDOFF_CYCLES  (HOLD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .trigger     (trigger),
    .distance_cm (distance_cm),
    .echo        (echo),
    .busy        (busy),
    .timeout     (timeout),
    .runt        (runt)
  );

  always #10 clock = ~clock;

  always @(negedge clock) begin
    if (runt === 1'b1) runt_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  function automatic int exp_width(input int d);
    return (d >= MINC && d <= MAXC) ? d * CPC : TMO;
  endfunction

  function automatic int exp_oor(input int d);
    return (d >= MINC && d <= MAXC) ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int w);
    @(negedge clock);
    trigger = 1'b1;
    repeat (w) @(negedge clock);
    trigger = 1'b0;
  endtask

  // Watches one measurement from the trigger fall onward; optional extra trigger in [ton, toff).
  task automatic run_meas(input int ton, input int toff,
                          output int rise_i, output int fall_i, output int bfall_i,
                          output int rises, output int to_at_fall, output int busy_at_rise);
    logic pe, pb;
    pe = 1'b0; pb = 1'b0;
    rise_i = 0; fall_i = 0; bfall_i = 0; rises = 0; to_at_fall = 0; busy_at_rise = 0;
    for (int i = 1; i <= LIMIT; i++) begin
      @(posedge clock);
      #1;
      if (ton > 0) trigger = (i >= ton && i < toff);
      if (i == 5) distance_cm = 9'($urandom_range(0, 511));
      if (echo === 1'b1 && !pe) begin
        rises++;
        if (rise_i == 0) begin
          rise_i = i;
          busy_at_rise = int'(busy);
        end
      end
      if (echo === 1'b0 && pe && fall_i == 0) begin
        fall_i = i;
        to_at_fall = int'(timeout);
      end
      if (busy === 1'b0 && pb) begin
        bfall_i = i;
        break;
      end
      pe = (echo === 1'b1);
      pb = (busy === 1'b1);
    end
  endtask

  task automatic measure(input string tag, input int w, input int d, input int ton, input int toff);
    int r, f, bf, nr, tf, br, runt0, to0;
    logic seen_echo, seen_busy;
    runt0 = runt_cnt;
    to0   = to_cnt;
    distance_cm = 9'(d);
    pulse(w);
    if (w >= TMIN) begin
      run_meas(ton, toff, r, f, bf, nr, tf, br);
      chk({tag, "_busyfall_seen"}, 32'(bf != 0), 32'd1);
      chk({tag, "_latency"}, 32'(r - 1), 32'(BST + 3));
      chk({tag, "_width"}, 32'(f - r), 32'(exp_width(d)));
      chk({tag, "_busy_at_rise"}, 32'(br), 32'd1);
      chk({tag, "_timeout_at_fall"}, 32'(tf), 32'(exp_oor(d)));
      chk({tag, "_holdoff"}, 32'(bf - f), 32'(HOLD));
      chk({tag, "_echo_count"}, 32'(nr), 32'd1);
      chk({tag, "_timeout_count"}, 32'(to_cnt - to0), 32'(exp_oor(d)));
      chk({tag, "_no_runt"}, 32'(runt_cnt - runt0), 32'd0);
    end else begin
      seen_echo = 1'b0;
      seen_busy = 1'b0;
      repeat (BST + 20) begin
        @(posedge clock);
        #1;
        if (echo !== 1'b0) seen_echo = 1'b1;
        if (busy !== 1'b0) seen_busy = 1'b1;
      end
      chk({tag, "_runt_count"}, 32'(runt_cnt - runt0), 32'd1);
      chk({tag, "_runt_no_echo"}, 32'(seen_echo), 32'd0);
      chk({tag, "_runt_no_busy"}, 32'(seen_busy), 32'd0);
    end
  endtask

  initial begin
    int w, d, runt0, k;
    logic seen_echo;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_echo", 32'(echo), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_runt", 32'(runt), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    measure("accept_2cm", TMIN, 2, 0, 0);
    measure("accept_10cm", TMIN, 10, 0, 0);
    measure("max_cm", TMIN, MAXC, 0, 0);
    measure("runt", TMIN - 1, 5, 0, 0);
    measure("after_runt", TMIN, 5, 0, 0);
    measure("oor_high", TMIN + 3, MAXC + 1, 0, 0);
    measure("oor_zero", TMIN, 0, 0, 0);
    measure("below_min", TMIN, MINC - 1, 0, 0);
    measure("oor_511", TMIN, 511, 0, 0);

    // Extra triggers during ECHO and during HOLDOFF must be ignored.
    measure("ign_echo", TMIN, 30, BST + 6, BST + 6 + TMIN);
    measure("ign_hold", TMIN, 3, BST + 4 + 3 * CPC + 5, BST + 4 + 3 * CPC + 5 + TMIN);

    // Trigger rises in HOLDOFF and is still high when IDLE is re-entered: ignored.
    measure("held_trig", TMIN, 4, BST + 4 + 4 * CPC + 10, 1_000_000);
    runt0 = runt_cnt;
    seen_echo = 1'b0;
    repeat (TMIN + 5) @(negedge clock);
    trigger = 1'b0;
    repeat (BST + 20) begin
      @(posedge clock);
      #1;
      if (echo !== 1'b0) seen_echo = 1'b1;
    end
    chk("held_trig_no_echo", 32'(seen_echo), 32'd0);
    chk("held_trig_no_runt", 32'(runt_cnt - runt0), 32'd0);

    // Reset in the middle of the echo pulse.
    distance_cm = 9'd30;
    pulse(TMIN);
    k = 0;
    while (echo !== 1'b1 && k < BST + 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("rst_echo_seen", 32'(echo), 32'd1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_mid_echo", 32'(echo), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    measure("post_reset", TMIN, 6, 0, 0);

    // Back-to-back: each trigger begins right after busy falls.
    measure("b2b_1", TMIN, 2, 0, 0);
    measure("b2b_2", TMIN, 10, 0, 0);
    measure("b2b_3", TMIN, 3, 0, 0);

    for (int n = 0; n < 14; n++) begin
      w = $urandom_range(TMIN - 3, TMIN + 10);
      if (n % 4 == 3) d = $urandom_range(0, 511);
      else d = $urandom_range(0, MAXC + 3);
      measure("rand", w, d, 0, 0);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
